// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register: owns the PC, keeps one
// memory request in flight, buffers one word across decode stalls, and squashes wrong-path fetches.
module fetch_stage #(
   parameter int               Width    = 32,
   parameter logic [Width-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [Width-1:0] imem_addr,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   input  logic             redirect_valid,
   input  logic [Width-1:0] redirect_pc,
   input  logic             stall,
   output logic             id_valid,
   output logic [31:0]      id_inst,
   output logic [Width-1:0] id_pc,
   output logic [Width-1:0] id_pc_plus4,
   output logic [1:0]       dbg_state,
   output logic             dbg_buf_valid
);

   // Request channel: a request is offered while valid=1 and is accepted on the
   // rising edge where valid=1 and ready=1; valid and address do not change while
   // waiting for ready. Responses come back in order, one per accepted request.
   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t           r_state;
   logic [Width-1:0] r_pc;
   logic [Width-1:0] r_req_pc;
   logic             r_drop;
   logic             r_buf_valid;
   logic [31:0]      r_buf_inst;
   logic [Width-1:0] r_buf_pc;
   logic             r_id_valid;
   logic [31:0]      r_id_inst;
   logic [Width-1:0] r_id_pc;
   logic [Width-1:0] r_id_pc_plus4;

   logic             w_hs;
   logic             w_rsp_keep;
   logic [Width-1:0] w_redir_pc;

   assign imem_req_valid = (r_state == S_REQ) && !r_buf_valid;
   assign imem_addr      = r_pc;
   assign w_hs           = imem_req_valid && imem_req_ready;
   assign w_rsp_keep     = (r_state == S_WAIT) && imem_rsp_valid && !r_drop;
   assign w_redir_pc     = redirect_pc & ~Width'(3);

   assign id_valid      = r_id_valid;
   assign id_inst       = r_id_inst;
   assign id_pc         = r_id_pc;
   assign id_pc_plus4   = r_id_pc_plus4;
   assign dbg_state     = r_state;
   assign dbg_buf_valid = r_buf_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_BOOT;
         r_pc          <= RESET_PC;
         r_req_pc      <= '0;
         r_drop        <= 1'b0;
         r_buf_valid   <= 1'b0;
         r_buf_inst    <= NOP;
         r_buf_pc      <= '0;
         r_id_valid    <= 1'b0;
         r_id_inst     <= NOP;
         r_id_pc       <= '0;
         r_id_pc_plus4 <= '0;
      end else if (redirect_valid) begin
         // Redirect flushes everything; an in-flight or just-accepted fetch is marked for discard.
         r_pc        <= w_redir_pc;
         r_id_valid  <= 1'b0;
         r_buf_valid <= 1'b0;
         case (r_state)
            S_BOOT: r_state <= S_REQ;
            S_REQ: begin
               if (w_hs) begin
                  r_req_pc <= r_pc;
                  r_drop   <= 1'b1;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  r_drop  <= 1'b0;
                  r_state <= S_REQ;
               end else begin
                  r_drop <= 1'b1;
               end
            end
            default: r_state <= S_BOOT;
         endcase
      end else begin
         case (r_state)
            S_BOOT: r_state <= S_REQ;
            S_REQ: begin
               if (w_hs) begin
                  r_req_pc <= r_pc;
                  r_pc     <= r_pc + Width'(4);
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  r_drop  <= 1'b0;
                  r_state <= S_REQ;
               end
            end
            default: r_state <= S_BOOT;
         endcase

         if (!stall) begin
            if (r_buf_valid) begin
               r_id_valid    <= 1'b1;
               r_id_inst     <= r_buf_inst;
               r_id_pc       <= r_buf_pc;
               r_id_pc_plus4 <= r_buf_pc + Width'(4);
               r_buf_valid   <= 1'b0;
            end else if (w_rsp_keep) begin
               r_id_valid    <= 1'b1;
               r_id_inst     <= imem_rsp_data;
               r_id_pc       <= r_req_pc;
               r_id_pc_plus4 <= r_req_pc + Width'(4);
            end else begin
               r_id_valid <= 1'b0;
            end
         end else if (w_rsp_keep) begin
            // Stalled: an empty IF/ID still takes the word, otherwise it parks in the buffer.
            if (!r_id_valid && !r_buf_valid) begin
               r_id_valid    <= 1'b1;
               r_id_inst     <= imem_rsp_data;
               r_id_pc       <= r_req_pc;
               r_id_pc_plus4 <= r_req_pc + Width'(4);
            end else begin
               r_buf_valid <= 1'b1;
               r_buf_inst  <= imem_rsp_data;
               r_buf_pc    <= r_req_pc;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a stream-level reference model.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [1:0]  dbg_state;
   logic        dbg_buf_valid;

   int checks = 0;
   int errors = 0;

   fetch_stage #(.Width(32), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .id_valid       (id_valid),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4),
      .dbg_state      (dbg_state),
      .dbg_buf_valid  (dbg_buf_valid)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h00A0_0113;
      return {a[15:0], ~a[17:2]} ^ 32'h1357_9BDF;
   endfunction

   // memory model: in-order responses after a programmable delay
   int          ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
   int          lat_min = 0;
   int          lat_max = 0;
   logic [31:0] mq_addr[$];
   int          mq_cnt[$];
   logic        m_hs;
   logic        m_rsp;
   logic [31:0] m_addr;

   initial begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      forever begin
         @(negedge clk);
         m_hs   = imem_req_valid && imem_req_ready;
         m_rsp  = imem_rsp_valid;
         m_addr = imem_addr;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            mq_addr.delete();
            mq_cnt.delete();
            imem_rsp_valid = 1'b0;
         end else begin
            if (m_rsp && mq_addr.size() > 0) begin
               void'(mq_addr.pop_front());
               void'(mq_cnt.pop_front());
            end
            if (m_hs) begin
               mq_addr.push_back(m_addr);
               mq_cnt.push_back(int'($urandom_range(lat_max, lat_min)));
            end
            imem_rsp_valid = 1'b0;
            if (mq_addr.size() > 0) begin
               if (mq_cnt[0] == 0) begin
                  imem_rsp_valid = 1'b1;
                  imem_rsp_data  = mem_word(mq_addr[0]);
               end else begin
                  mq_cnt[0] = mq_cnt[0] - 1;
               end
            end
         end
         case (ready_mode)
            0:       imem_req_ready = 1'b1;
            2:       imem_req_ready = 1'b0;
            default: imem_req_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // scoreboard: the decode side must see the fetch stream from the last
   // redirect (or reset) in order, each word tagged with its own address
   int          held;
   logic [31:0] exp_pc;
   logic [31:0] exp_req;
   bit          ost_q[$];
   bit          prev_pend;
   logic [31:0] prev_addr;
   int          idle;

   initial begin
      held = 0; exp_pc = 0; exp_req = 0; prev_pend = 0; prev_addr = 0; idle = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held      = 0;
            exp_pc    = 32'h0;
            exp_req   = 32'h0;
            ost_q.delete();
            prev_pend = 0;
            idle      = 0;
         end else begin
            bit   hs;
            bit   st;
            int   kept;
            int   cons;
            logic [31:0] tgt;
            chk("id_valid", id_valid, (held > 0));
            if (held > 0) begin
               chk("id_pc", id_pc, exp_pc);
               chk("id_inst", id_inst, mem_word(exp_pc));
               chk("id_pc_plus4", id_pc_plus4, exp_pc + 32'd4);
            end
            if (imem_req_valid) chk("req_addr", imem_addr, exp_req);
            if (ost_q.size() > 0) chk("no_req_while_outstanding", imem_req_valid, 0);
            if (held >= 2) chk("no_req_while_buffer_full", imem_req_valid, 0);
            if (prev_pend) begin
               chk("req_valid_held", imem_req_valid, 1);
               chk("req_addr_held", imem_addr, prev_addr);
            end

            hs   = imem_req_valid && imem_req_ready;
            kept = 0;
            cons = 0;
            tgt  = redirect_pc & 32'hFFFF_FFFC;
            if (imem_rsp_valid && ost_q.size() > 0) begin
               st   = ost_q.pop_front();
               kept = (!st && !redirect_valid) ? 1 : 0;
            end
            if (redirect_valid) begin
               foreach (ost_q[i]) ost_q[i] = 1'b1;
               held    = 0;
               exp_pc  = tgt;
               exp_req = tgt;
            end else begin
               cons = (held > 0 && !stall) ? 1 : 0;
               held = held - cons + kept;
               if (cons == 1) exp_pc = exp_pc + 32'd4;
               if (hs) exp_req = imem_addr + 32'd4;
            end
            if (hs) ost_q.push_back(redirect_valid);
            prev_pend = imem_req_valid && !imem_req_ready && !redirect_valid;
            prev_addr = imem_addr;

            if (hs || cons == 1 || redirect_valid) idle = 0;
            else idle++;
            if (idle > 64) begin
               chk("progress_watchdog", idle, 0);
               idle = 0;
            end
         end
      end
   end

   // driver tasks
   task automatic reset_release();
      @(posedge clk);
      #1;
      rst_n          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   bit          t1_rv  [8];
   bit          t1_idv [8];
   logic [31:0] t1_addr[8];
   logic [31:0] t1_pc  [8];
   logic [31:0] t1_p4  [8];

   initial begin
      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      t1_rv   = '{0, 1, 0, 1, 0, 1, 0, 1};
      t1_addr = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'h0, 32'hC};
      t1_idv  = '{0, 0, 0, 1, 0, 1, 0, 1};
      t1_pc   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8};
      t1_p4   = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'h0, 32'hC};

      // reset release and back-to-back fetch with zero-wait memory
      reset_release();
      @(negedge clk);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_id_valid", id_valid, 0);
      chk("rst_id_inst", id_inst, 32'h0000_0013);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_pc_plus4", id_pc_plus4, 32'h0);
      chk("rst_buf_valid", dbg_buf_valid, 0);
      for (int n = 1; n <= 7; n++) begin
         step();
         @(negedge clk);
         chk("seq_req_valid", imem_req_valid, t1_rv[n]);
         if (t1_rv[n]) chk("seq_addr", imem_addr, t1_addr[n]);
         chk("seq_id_valid", id_valid, t1_idv[n]);
         if (t1_idv[n]) begin
            chk("seq_id_pc", id_pc, t1_pc[n]);
            chk("seq_id_pc_plus4", id_pc_plus4, t1_p4[n]);
         end
      end

      // memory not ready for three cycles while a request at 0x4 is pending
      reset_release();
      for (int n = 1; n <= 8; n++) begin
         step();
         @(negedge clk);
         if (n >= 3 && n <= 6) begin
            chk("backpressure_req_valid", imem_req_valid, 1);
            chk("backpressure_addr", imem_addr, 32'h4);
         end
         if (n == 7) chk("backpressure_accepted", imem_req_valid, 0);
         if (n == 8) chk("backpressure_id_pc", id_pc, 32'h4);
         if (n == 2) ready_mode = 2;
         if (n == 5) ready_mode = 0;
      end

      // decode stall for four cycles absorbs one word in the buffer
      reset_release();
      for (int n = 1; n <= 8; n++) begin
         step();
         if (n == 3) stall = 1'b1;
         if (n == 7) stall = 1'b0;
         @(negedge clk);
         if (n == 3) chk("stall_first_inst", id_inst, 32'h0050_0093);
         if (n >= 5 && n <= 7) begin
            chk("stall_hold_inst", id_inst, 32'h0050_0093);
            chk("stall_buf_valid", dbg_buf_valid, 1);
            chk("stall_no_req", imem_req_valid, 0);
         end
         if (n == 8) begin
            chk("stall_release_inst", id_inst, 32'h00A0_0113);
            chk("stall_release_pc", id_pc, 32'h4);
            chk("stall_release_buf", dbg_buf_valid, 0);
            chk("stall_resume_req", imem_req_valid, 1);
            chk("stall_resume_addr", imem_addr, 32'h8);
         end
      end

      // redirect while waiting; stale response arrives two cycles later
      lat_min = 2; lat_max = 2;
      reset_release();
      for (int n = 1; n <= 9; n++) begin
         step();
         redirect_valid = (n == 2);
         redirect_pc    = 32'h100;
         @(negedge clk);
         if (n >= 3 && n <= 8) chk("wait_redir_id_valid", id_valid, 0);
         if (n == 5) begin
            chk("wait_redir_req_valid", imem_req_valid, 1);
            chk("wait_redir_addr", imem_addr, 32'h100);
         end
         if (n == 9) begin
            chk("wait_redir_id_valid_new", id_valid, 1);
            chk("wait_redir_id_pc", id_pc, 32'h100);
            chk("wait_redir_id_pc_plus4", id_pc_plus4, 32'h104);
         end
      end

      // redirect coinciding with the handshake at 0x8
      lat_min = 0; lat_max = 0;
      reset_release();
      for (int n = 1; n <= 9; n++) begin
         step();
         redirect_valid = (n == 5);
         redirect_pc    = 32'h40;
         @(negedge clk);
         if (n == 6 || n == 7) chk("req_redir_flush", id_valid, 0);
         if (n == 7) begin
            chk("req_redir_req_valid", imem_req_valid, 1);
            chk("req_redir_addr", imem_addr, 32'h40);
         end
         if (n == 9) begin
            chk("req_redir_id_pc", id_pc, 32'h40);
            chk("req_redir_next_addr", imem_addr, 32'h44);
         end
      end

      // asynchronous reset while the buffer is full
      reset_release();
      for (int n = 1; n <= 6; n++) begin
         step();
         if (n == 3) stall = 1'b1;
         @(negedge clk);
         if (n == 6) chk("areset_pre_buf_valid", dbg_buf_valid, 1);
      end
      step();
      rst_n = 1'b0;
      #1;
      chk("areset_id_valid", id_valid, 0);
      chk("areset_id_inst", id_inst, 32'h0000_0013);
      chk("areset_id_pc", id_pc, 32'h0);
      chk("areset_id_pc_plus4", id_pc_plus4, 32'h0);
      chk("areset_req_valid", imem_req_valid, 0);
      chk("areset_buf_valid", dbg_buf_valid, 0);
      stall = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("areset_boot_no_req", imem_req_valid, 0);
      step();
      @(negedge clk);
      chk("areset_restart_req", imem_req_valid, 1);
      chk("areset_restart_addr", imem_addr, 32'h0);

      // randomized traffic with back-pressure, latency, stalls, redirects and a reset
      ready_mode = 1; lat_min = 0; lat_max = 2;
      reset_release();
      for (int i = 0; i < 3000; i++) begin
         step();
         stall          = ($urandom_range(0, 3) == 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         else redirect_pc = $urandom & 32'h0000_0FFF;
         if (i == 1500) rst_n = 1'b0;
         if (i == 1503) rst_n = 1'b1;
      end
      step();
      stall = 1'b0;
      redirect_valid = 1'b0;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL timeout: bench did not complete, got running expected finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
